// File: rtl/merge_arbiter_pkg.sv
// Shared router forwarding definitions: packet layout and arbiter state encoding.
package merge_arbiter_pkg;
  localparam int PACKET_WIDTH = 30;
  localparam int DX_MSB = 29;
  localparam int DX_LSB = 26;
  localparam int DY_MSB = 25;
  localparam int DY_LSB = 22;

  typedef enum logic {IDLE, BURST} arb_state_t;
endpackage

// File: rtl/merge_arbiter_if.sv
// Merge arbiter bus: input FIFO side, output FIFO backpressure and the forwarded packet.
interface merge_arbiter_if #(
  parameter int DATA_WIDTH = 30,
  parameter int NUM_IN     = 2
);
  localparam int IDX_W = $clog2(NUM_IN);

  logic [NUM_IN*DATA_WIDTH-1:0] din;
  logic [NUM_IN-1:0]            empty;
  logic                         out_full;
  logic                         out_almost_full;
  logic [NUM_IN-1:0]            read_en;
  logic [DATA_WIDTH-1:0]        dout;
  logic                         wen;
  logic [IDX_W-1:0]             grant_idx;

  // master is the arbiter, slave is the surrounding FIFOs
  modport master (input din, empty, out_full, out_almost_full,
                  output read_en, dout, wen, grant_idx);
  modport slave  (output din, empty, out_full, out_almost_full,
                  input read_en, dout, wen, grant_idx);
endinterface

// File: rtl/merge_arbiter_rr_select.sv
// Rotate-priority encoder: first set req bit at or after ptr, wrapping modulo NUM_IN.
module rr_select #(
  parameter  int NUM_IN = 2,
  localparam int IDX_W  = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic              valid,
  output logic [IDX_W-1:0]  idx
);
  always_comb begin
    valid = 1'b0;
    idx   = ptr;
    // walk from farthest to nearest so the closest requester wins
    for (int k = NUM_IN - 1; k >= 0; k--) begin
      int j;
      j = (int'(ptr) + k) % NUM_IN;
      if (req[j]) begin
        valid = 1'b1;
        idx   = IDX_W'(j);
      end
    end
  end
endmodule

// File: rtl/merge_arbiter.sv
// Round-robin burst arbiter merging NUM_IN FWFT FIFOs into one registered forwarding path.
// MERGE_ARB_STATS_EN adds per-input grant counters and a stall counter.
module merge_arbiter
  import merge_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = PACKET_WIDTH,
  parameter int NUM_IN     = 2,
  parameter int MAX_BURST  = 4
) (
  input  logic               clk,
  input  logic               rst,
  merge_arbiter_if.master    bus
`ifdef MERGE_ARB_STATS_EN
  ,
  output logic [NUM_IN*16-1:0] grant_cnt,
  output logic [15:0]          stall_cnt
`endif
);
  localparam int IDX_W = $clog2(NUM_IN);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_t        state, state_nxt;
  logic [IDX_W-1:0]  cur, cur_nxt, rr_ptr, rr_ptr_nxt, cur_inc, sel_ptr, sel_idx;
  logic [CNT_W-1:0]  burst_cnt, burst_nxt;
  logic [NUM_IN-1:0] req, grant;
  logic              sel_vld, stall, rotate;

  assign req     = ~bus.empty;
  // almost_full only matters when a word is already in flight
  assign stall   = bus.out_full | (bus.out_almost_full & bus.wen);
  assign rotate  = (state == BURST) & (bus.empty[cur] | (burst_cnt == CNT_W'(MAX_BURST)));
  assign cur_inc = (cur == IDX_W'(NUM_IN - 1)) ? '0 : cur + 1'b1;
  assign sel_ptr = rotate ? cur_inc : rr_ptr;

  rr_select #(.NUM_IN(NUM_IN)) u_sel (
    .req   (req),
    .ptr   (sel_ptr),
    .valid (sel_vld),
    .idx   (sel_idx)
  );

  always_comb begin
    state_nxt  = state;
    cur_nxt    = cur;
    burst_nxt  = burst_cnt;
    rr_ptr_nxt = rr_ptr;
    grant      = '0;
    if (!stall) begin
      case (state)
        IDLE: if (sel_vld) begin
          grant[sel_idx] = 1'b1;
          cur_nxt        = sel_idx;
          burst_nxt      = CNT_W'(1);
          state_nxt      = BURST;
        end
        BURST: if (rotate) begin
          rr_ptr_nxt = cur_inc;
          if (sel_vld) begin
            grant[sel_idx] = 1'b1;
            cur_nxt        = sel_idx;
            burst_nxt      = CNT_W'(1);
          end else begin
            burst_nxt = '0;
            state_nxt = IDLE;
          end
        end else begin
          grant[cur] = 1'b1;
          burst_nxt  = burst_cnt + 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign bus.read_en = grant & {NUM_IN{rst}};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      cur           <= '0;
      rr_ptr        <= '0;
      burst_cnt     <= '0;
      bus.wen       <= 1'b0;
      bus.dout      <= '0;
      bus.grant_idx <= '0;
    end else begin
      state     <= state_nxt;
      cur       <= cur_nxt;
      rr_ptr    <= rr_ptr_nxt;
      burst_cnt <= burst_nxt;
      bus.wen   <= |grant;
      if (|grant) begin
        bus.dout      <= bus.din[int'(cur_nxt)*DATA_WIDTH +: DATA_WIDTH];
        bus.grant_idx <= cur_nxt;
      end
    end
  end

`ifdef MERGE_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (bus.wen && grant_cnt[int'(bus.grant_idx)*16 +: 16] != 16'hFFFF)
        grant_cnt[int'(bus.grant_idx)*16 +: 16] <= grant_cnt[int'(bus.grant_idx)*16 +: 16] + 16'd1;
      if (stall && |req && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

  a_rd_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(bus.read_en));
  a_rd_empty:  assert property (@(posedge clk) disable iff (!rst) (bus.read_en & bus.empty) == '0);
  a_wen_full:  assert property (@(posedge clk) disable iff (!rst) !(bus.wen && bus.out_full));
endmodule

// File: tb/tb_merge_arbiter.sv
// Randomized and directed bench for merge_arbiter against a queue-based behavioural model.
module tb_merge_arbiter;
  localparam int DW = 30, N = 2, MB = 4, OF_DEPTH = 4;

  typedef logic [DW-1:0] word_q_t[$];

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  merge_arbiter_if #(.DATA_WIDTH(DW), .NUM_IN(N)) bus ();
`ifdef MERGE_ARB_STATS_EN
  logic [N*16-1:0] grant_cnt;
  logic [15:0]     stall_cnt;
`endif

  merge_arbiter #(.DATA_WIDTH(DW), .NUM_IN(N), .MAX_BURST(MB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef MERGE_ARB_STATS_EN
    ,
    .grant_cnt (grant_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  int checks = 0, errors = 0;
  word_q_t q [N];
  int m_busy, m_cur, m_cnt, m_ptr, exp_gidx, of_cnt;
  int m_gcnt [N];
  int m_scnt;
  bit exp_wen, of_mode, f_full, f_af;
  logic [DW-1:0] exp_dout;
  logic [N-1:0]  rd_obs;
  logic          wen_obs;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic int first_from(int p, logic [N-1:0] emp);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (p + k) % N;
      if (!emp[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_cur = 0; m_cnt = 0; m_ptr = 0;
    exp_wen = 0; exp_dout = '0; exp_gidx = 0; of_cnt = 0;
    for (int i = 0; i < N; i++) begin
      m_gcnt[i] = 0;
      q[i].delete();
    end
    m_scnt = 0;
  endtask

  task automatic fill(int i, int n);
    for (int k = 0; k < n; k++) q[i].push_back(DW'($urandom));
  endtask

  // one clock: drive at edge+1, compare at edge+2, advance model across the edge
  task automatic step();
    logic [N-1:0] emp;
    bit stl;
    int g;
    for (int i = 0; i < N; i++) begin
      emp[i] = (q[i].size() == 0);
      if (!emp[i]) bus.din[i*DW +: DW] = q[i][0];
    end
    bus.empty = emp;
    if (of_mode) begin
      bus.out_full        = (of_cnt >= OF_DEPTH);
      bus.out_almost_full = (of_cnt >= OF_DEPTH - 1);
    end else begin
      bus.out_full        = f_full;
      bus.out_almost_full = f_af;
    end
    #1;
    stl = bus.out_full | (bus.out_almost_full & exp_wen);
    g = -1;
    if (!stl) begin
      if (m_busy == 0) begin
        g = first_from(m_ptr, emp);
        if (g >= 0) begin m_busy = 1; m_cur = g; m_cnt = 1; end
      end else if (!emp[m_cur] && m_cnt < MB) begin
        g = m_cur;
        m_cnt++;
      end else begin
        m_ptr = (m_cur + 1) % N;
        g = first_from(m_ptr, emp);
        if (g >= 0) begin m_cur = g; m_cnt = 1; end
        else begin m_busy = 0; m_cnt = 0; end
      end
    end
    rd_obs  = bus.read_en;
    wen_obs = bus.wen;
    chk("read_en", 64'(bus.read_en), (g >= 0) ? 64'(1 << g) : 64'd0);
    chk("wen", 64'(bus.wen), 64'(exp_wen));
    chk("dout", 64'(bus.dout), 64'(exp_dout));
    chk("grant_idx", 64'(bus.grant_idx), 64'(exp_gidx));
    if (of_mode) chk("no_overflow", 64'(bus.wen && of_cnt >= OF_DEPTH), 64'd0);
    if (exp_wen) m_gcnt[exp_gidx]++;
    if (stl && emp != '1) m_scnt++;
    @(posedge clk);
    if (exp_wen) of_cnt++;
    if (of_cnt > 0 && $urandom_range(0, 2) == 0) of_cnt--;
    exp_wen = (g >= 0);
    if (g >= 0) begin
      exp_dout = q[g].pop_front();
      exp_gidx = g;
    end
    #1;
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_read_en"}, 64'(bus.read_en), 64'd0);
    chk({tag, "_wen"}, 64'(bus.wen), 64'd0);
    chk({tag, "_dout"}, 64'(bus.dout), 64'd0);
    chk({tag, "_grant_idx"}, 64'(bus.grant_idx), 64'd0);
`ifdef MERGE_ARB_STATS_EN
    chk({tag, "_grant_cnt"}, 64'(grant_cnt), 64'd0);
    chk({tag, "_stall_cnt"}, 64'(stall_cnt), 64'd0);
`endif
  endtask

  // async reset asserted between edges; upstream FIFOs are cleared along with it
  task automatic do_reset(string tag);
    rst = 1'b0;
    #1;
    check_zero(tag);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    logic [15:0] seq16;
    logic [5:0]  s0, s1, sw;
    int n;
    of_mode = 0; f_full = 0; f_af = 0;
    model_reset();
    bus.din = '0; bus.empty = '0; bus.out_full = 1'b0; bus.out_almost_full = 1'b0;

    // reset held with requests pending, then first grant to input 0
    fill(0, 40); fill(1, 40);
    repeat (3) @(posedge clk);
    #1;
    check_zero("t1_rst");
    rst = 1'b1;
    seq16 = '0; n = 0;
    for (int c = 0; c < 16; c++) begin
      step();
      if (c == 0) chk("t1_first_read_en", 64'(rd_obs), 64'd1);
      seq16 = {seq16[14:0], rd_obs[1]};
      if (c > 0 && wen_obs) n++;
    end
    chk("t2_grant_seq", 64'(seq16), 64'h0F0F);
    chk("t2_wen_count", 64'(n), 64'd15);

    // single requester with 3 words, then idle
    do_reset("t3_rst");
    fill(1, 3);
    s1 = '0; sw = '0;
    for (int c = 0; c < 6; c++) begin
      step();
      s1 = {s1[4:0], rd_obs[1]};
      sw = {sw[4:0], wen_obs};
    end
    chk("t3_read_en1_seq", 64'(s1), 64'b111000);
    chk("t3_wen_seq", 64'(sw), 64'b011100);

    // input 0 drains mid-burst, input 1 takes over with no bubble
    do_reset("t5_rst");
    fill(0, 2); fill(1, 3);
    s0 = '0; s1 = '0;
    for (int c = 0; c < 6; c++) begin
      step();
      s0 = {s0[4:0], rd_obs[0]};
      s1 = {s1[4:0], rd_obs[1]};
    end
    chk("t5_read_en0_seq", 64'(s0), 64'b110000);
    chk("t5_read_en1_seq", 64'(s1), 64'b001110);

    // almost_full with word in flight, then full for 5 cycles; burst resumes
    do_reset("t4_rst");
    fill(0, 20); fill(1, 20);
    step(); step();
    f_af = 1;
    step();
    chk("t4_af_stall", 64'(rd_obs), 64'd0);
    f_full = 1;
    n = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      n += int'(wen_obs) + int'(rd_obs != '0);
    end
    chk("t4_full_quiet", 64'(n), 64'd0);
    f_full = 0; f_af = 0;
    s0 = '0; s1 = '0;
    for (int c = 0; c < 3; c++) begin
      step();
      s0 = {s0[4:0], rd_obs[0]};
      s1 = {s1[4:0], rd_obs[1]};
    end
    chk("t4_resume0", 64'(s0), 64'b110);
    chk("t4_resume1", 64'(s1), 64'b001);

    // reset mid-burst drops the popped word and restarts at input 0
    do_reset("t6_pre");
    fill(0, 20); fill(1, 20);
    step(); step();
    do_reset("t6_mid");
    fill(0, 20); fill(1, 20);
    step();
    chk("t6_restart", 64'(rd_obs), 64'd1);

    // randomized traffic against a modelled output FIFO
    do_reset("rnd_rst");
    of_mode = 1;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 99) < ((c / 300) % 2 == 0 ? 70 : 25) + i * 10 && q[i].size() < 8)
          fill(i, 1);
      step();
    end
`ifdef MERGE_ARB_STATS_EN
    for (int i = 0; i < N; i++) chk("stat_grant_cnt", 64'(grant_cnt[i*16 +: 16]), 64'(m_gcnt[i]));
    chk("stat_stall_cnt", 64'(stall_cnt), 64'(m_scnt));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
